// File: rtl/score_display_ctrl.sv
// Converts two binary scores (saturated to 99) to packed BCD by shift-add-3 and loads both display registers together.
// Optional display blinking is compiled in only when SCORE_BLINK_EN is defined.
module score_display_ctrl #(
    parameter int BLINK_HALF = 250
) (
    input  logic       clk_1k,
    input  logic       rst_n,
    input  logic [6:0] left_bin,
    input  logic [6:0] right_bin,
    input  logic       update,
    input  logic       blink_req,
    output logic [7:0] left_value,
    output logic [7:0] right_value,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, CONV_L, CONV_R, LOAD} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [14:0] work_l_q, work_l_d;
    logic [14:0] work_r_q, work_r_d;
    logic        pending_q, pending_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  left_value_q, left_value_d;
    logic [7:0]  right_value_q, right_value_d;

    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    // One double-dabble step on {tens, ones, binary}: adjust nibbles >= 5, then shift left.
    function automatic logic [14:0] dd_step(input logic [14:0] w);
        logic [14:0] a;
        a = w;
        if (a[10:7] >= 4'd5)  a[10:7]  = a[10:7] + 4'd3;
        if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
        return {a[13:0], 1'b0};
    endfunction

    // NOTE: every next-state signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        work_l_d      = work_l_q;
        work_r_d      = work_r_q;
        pending_d     = pending_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        left_value_d  = left_value_q;
        right_value_d = right_value_q;

        case (state_q)
            IDLE: begin
                if (update || pending_q) begin
                    work_l_d  = {8'd0, sat99(left_bin)};
                    work_r_d  = {8'd0, sat99(right_bin)};
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = 3'd0;
                    state_d   = CONV_L;
                end
            end
            CONV_L: begin
                work_l_d = dd_step(work_l_q);
                if (cnt_q == 3'd6) begin
                    cnt_d   = 3'd0;
                    state_d = CONV_R;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            CONV_R: begin
                work_r_d = dd_step(work_r_q);
                if (cnt_q == 3'd6) begin
                    cnt_d   = 3'd0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            LOAD: begin
                left_value_d  = work_l_q[14:7];
                right_value_d = work_r_q[14:7];
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Requests arriving mid-conversion (LOAD included) collapse into one rerun.
        if (state_q != IDLE && update) pending_d = 1'b1;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    // NOTE: the conversion work registers are reset too; they are tiny and it keeps X out of the datapath.
    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            work_l_q      <= '0;
            work_r_q      <= '0;
            pending_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            left_value_q  <= 8'h00;
            right_value_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            work_l_q      <= work_l_d;
            work_r_q      <= work_r_d;
            pending_q     <= pending_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            left_value_q  <= left_value_d;
            right_value_q <= right_value_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef SCORE_BLINK_EN
    localparam int CW = $clog2(BLINK_HALF + 1);

    logic [CW-1:0] blink_cnt_q;
    logic          blank_q;

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else if (!blink_req) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else if (blink_cnt_q == CW'(BLINK_HALF - 1)) begin
            blink_cnt_q <= '0;
            blank_q     <= ~blank_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // Blanking only masks the view; stored digits and handshake are untouched.
    assign left_value  = blank_q ? 8'hFF : left_value_q;
    assign right_value = blank_q ? 8'hFF : right_value_q;
`else
    logic unused_blink;
    assign unused_blink = blink_req ^ BLINK_HALF[0];
    assign left_value   = left_value_q;
    assign right_value  = right_value_q;
`endif

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 SHALL have parameter BLINK_HALF, default 250, meaning clk_1k cycles per blink half-period.
REQ-002 SHALL have port clk_1k  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port left_bin  input  7  left score, unsigned binary.
REQ-005 SHALL have port right_bin  input  7  right score, unsigned binary.
REQ-006 SHALL have port update  input  1  request to convert and load both scores.
REQ-007 SHALL have port blink_req  input  1  level request to flash the display.
REQ-008 SHALL have port left_value  output  8  left display digits, packed BCD {tens,ones}, registered.
REQ-009 SHALL have port right_value  output  8  right display digits, packed BCD {tens,ones}, registered.
REQ-010 SHALL have port busy  output  1  conversion in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when new values are loaded.

Function
REQ-012 SHALL implement FSM states IDLE, CONV_L, CONV_R, LOAD.
REQ-013 SHALL capture left_bin/right_bin and leave IDLE at an edge E0 where state=IDLE and update=1 (or pending=1).
REQ-014 SHALL saturate each captured value above 99 to 99 at capture.
REQ-015 SHALL convert by shift-add-3 (double dabble): 7 CONV_L cycles (E1..E7), then 7 CONV_R cycles (E8..E14); add 3 to any BCD nibble >=5 before each shift.
REQ-016 SHALL write left_value/right_value at E15 (LOAD -> IDLE), assert done for exactly the following cycle, and deassert busy at E15.
REQ-017 SHALL assert busy from after E0 through E15, i.e. 15 cycles.
REQ-018 SHALL hold left_value/right_value stable between loads; an intermediate BCD value SHALL never appear on them.
REQ-019 SHALL set a one-deep pending flag when update=1 while busy=1; further updates while pending=1 are merged (no queue growth).
REQ-020 SHALL, when pending=1 at LOAD, clear pending and re-enter conversion from IDLE on the next edge, sampling inputs at that edge (latest values win).
REQ-021 SHALL treat update=1 in the same cycle as LOAD as pending (set, not lost).
REQ-022 SHALL ignore update held high across IDLE only as a level: each IDLE cycle with update=1 starts a conversion.

Reset
REQ-023 SHALL, on rst_n=0, immediately force state=IDLE, pending=0, busy=0, done=0, left_value=8'h00, right_value=8'h00, blink counter=0, blink phase=visible.
REQ-024 SHALL abandon any conversion in progress on reset; no done pulse and no partial load result.
REQ-025 SHALL require no update on the first edge after rst_n deasserts to be lost (it is accepted normally).

Configuration
REQ-026 SHALL compile blink support only when macro SCORE_BLINK_EN is defined.
REQ-027 With SCORE_BLINK_EN: while blink_req=1, a counter toggles phase every BLINK_HALF cycles; in blank phase left_value/right_value SHALL read 8'hFF (blank code), in visible phase the stored BCD; blink_req=0 resets counter and forces visible phase within one cycle.
REQ-028 Without SCORE_BLINK_EN: blink_req SHALL be ignored, no blink counter exists, outputs always show stored BCD.
REQ-029 Blink masking SHALL NOT affect busy, done, pending or stored values.

Verification
REQ-030 left_bin=42, right_bin=7, update pulse at E0 -> busy 15 cycles, at E15 left_value=8'h42, right_value=8'h07, done one cycle.
REQ-031 left_bin=127, right_bin=100, update -> left_value=8'h99, right_value=8'h99.
REQ-032 update with 12/34 at E0, update with 56/78 at E5 -> first load 8'h12/8'h34 at E15, second load 8'h56/8'h78 at E31, two done pulses.
REQ-033 rst_n low at E8 of a 42/7 conversion -> outputs 8'h00, busy=0, no done; next update converts normally.
REQ-034 SCORE_BLINK_EN, BLINK_HALF=4, stored 8'h42, blink_req=1 -> outputs alternate 8'h42 / 8'hFF every 4 cycles; blink_req=0 -> 8'h42 next cycle.
REQ-035 update held high 3 IDLE cycles plus through conversion -> exactly one pending rerun, no lockup.
